// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    localparam logic signed [W+1:0] ZERO = '0;

    logic        [W:0]   shifted;
    logic signed [W+1:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = $signed({1'b0, shifted}) - $signed({2'b00, divisor});
        q_bit   = (diff >= ZERO);
        // A non-negative difference is below the divisor, so its low W bits hold it exactly.
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 2W/W unsigned restoring divider with valid/ready handshakes on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    function automatic logic [W-1:0] q_sat();
        return '1;
    endfunction

    div_state_t    state, state_nx;
    logic          first;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_r, lo_r, dvs_r;
    logic          dz_r, ov_r;
    logic [W-1:0]  step_rem;
    logic          step_q;
    logic          accept, dz_hit, ov_hit, step_last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dz_hit    = (dvs_r == '0);
    assign ov_hit    = !dz_hit && (rem_r >= dvs_r);
    assign step_last = (cnt == '0);

    assign quotient  = lo_r;
    assign remainder = rem_r;
    assign div_zero  = dz_r;
    assign overflow  = ov_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                if (first) begin
                    if (dz_hit || ov_hit) state_nx = DONE;
                end else if (step_last) begin
                    state_nx = DONE;
                end
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    div_step #(.W(W)) u_step (
        .rem_in  (rem_r),
        .bit_in  (lo_r[W-1]),
        .divisor (dvs_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // rem_r:lo_r is the shifting {partial remainder, dividend} pair; quotient bits fill lo_r from the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first <= 1'b0;
            cnt   <= '0;
            rem_r <= '0;
            lo_r  <= '0;
            dvs_r <= '0;
            dz_r  <= 1'b0;
            ov_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_r <= dividend[2*W-1:W];
                        lo_r  <= dividend[W-1:0];
                        dvs_r <= divisor;
                        first <= 1'b1;
                        dz_r  <= 1'b0;
                        ov_r  <= 1'b0;
                    end
                end
                CALC: begin
                    if (first) begin
                        first <= 1'b0;
                        if (dz_hit) begin
                            dz_r  <= 1'b1;
                            rem_r <= lo_r;
                            lo_r  <= q_sat();
                        end else if (ov_hit) begin
                            ov_r  <= 1'b1;
                            rem_r <= '0;
                            lo_r  <= q_sat();
                        end else begin
                            cnt <= CNT_LOAD;
                        end
                    end else begin
                        rem_r <= step_rem;
                        lo_r  <= {lo_r[W-2:0], step_q};
                        if (!step_last) cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: reference quotients queued at issue, compared on out_valid.
module tb_seq_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    int   nvec = 0;
    int   nmis = 0;
    exp_t sb[$];

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t        e;
        logic [31:0] qq;
        logic [31:0] rr;
        if (dvs == 0) begin
            e = '{q: '1, r: dvd[W-1:0], dz: 1'b1, ov: 1'b0, lat: 1};
        end else if (dvd[2*W-1:W] >= dvs) begin
            e = '{q: '1, r: '0, dz: 1'b0, ov: 1'b1, lat: 1};
        end else begin
            qq = dvd / {16'b0, dvs};
            rr = dvd % {16'b0, dvs};
            e  = '{q: qq[W-1:0], r: rr[W-1:0], dz: 1'b0, ov: 1'b0, lat: W + 1};
        end
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_quotient"},  quotient,  0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_div_zero"},  div_zero,  0);
        check({tag, "_overflow"},  overflow,  0);
    endtask

    task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input int hold, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before", in_ready, 1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        push_exp(dvd, dvs);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = W'($urandom);
        check("busy_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = (poke && n == 4);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("latency", n, e.lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_q", quotient, e.q);
            check("hold_r", remainder, e.r);
        end
        check("quotient",  quotient,  e.q);
        check("remainder", remainder, e.r);
        check("div_zero",  div_zero,  e.dz);
        check("overflow",  overflow,  e.ov);
        if (!e.dz && !e.ov) begin
            check("identity", {48'b0, quotient} * {48'b0, dvs} + {48'b0, remainder}, {32'b0, dvd});
            check("rem_lt_dvs", remainder < dvs, 1);
        end
        // New request offered on the release edge must not be taken on that edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 32'd55;
        divisor   = 16'd5;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   rd;
        logic [2*W-1:0] rv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(32'd1000, 16'd7, 0, 1'b0);
        run_op(32'hFFFE0001, 16'hFFFF, 0, 1'b0);
        run_op(32'h00001234, 16'h0000, 0, 1'b0);
        run_op(32'h00010000, 16'h0001, 0, 1'b0);
        run_op(32'h0005ABCD, 16'h0005, 0, 1'b0);
        run_op(32'h0004FFFF, 16'h0005, 0, 1'b0);
        run_op(32'd1000, 16'd7, 5, 1'b1);
        run_op(32'h00000000, 16'h0000, 2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rd = W'($urandom_range(1, 65535));
            rv = {W'($urandom % rd), W'($urandom)};
            run_op(rv, rd, i % 2, 1'b0);
        end

        // Reset in the middle of a calculation: result is discarded.
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_calc_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 0);
        run_op(32'd100, 16'd10, 0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter W, default 16, giving divisor, quotient and remainder width; dividend width is 2*W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port dividend  input  2*W  unsigned numerator.
REQ-007 SHALL have port divisor  input  W  unsigned denominator.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  W  unsigned quotient.
REQ-011 SHALL have port remainder  output  W  unsigned remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero, valid with out_valid.
REQ-013 SHALL have port overflow  output  1  quotient exceeds W bits, valid with out_valid.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept an operation on an edge where in_valid && in_ready, and SHALL register dividend and divisor on that edge.
REQ-016 SHALL, on acceptance with divisor == 0, go directly to DONE: div_zero=1, overflow=0, quotient all-ones, remainder = dividend[W-1:0].
REQ-017 SHALL, on acceptance with divisor != 0 and dividend[2W-1:W] >= divisor, go directly to DONE: overflow=1, div_zero=0, quotient all-ones, remainder 0.
REQ-018 SHALL otherwise enter CALC and perform restoring division, one quotient bit per cycle, MSB first, for exactly W cycles, counted by a down-counter loaded with W-1.
REQ-019 SHALL, per CALC step, shift the {partial remainder, dividend} pair left by one, trial-subtract divisor from the W+1-bit partial remainder, keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-020 SHALL give latency: out_valid high after edge k+W+1 for acceptance at edge k (normal path), after edge k+1 for div_zero/overflow.
REQ-021 SHALL hold quotient, remainder, div_zero and overflow stable while out_valid && !out_ready, with no timeout.
REQ-022 SHALL return to IDLE on an edge where out_valid && out_ready; the next operation cannot be accepted on that same edge.
REQ-023 SHALL ignore in_valid, dividend and divisor changes outside IDLE.
REQ-024 SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every non-error result.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, counter=0.
REQ-026 SHALL, on reset asserted during CALC or DONE, abandon the operation with no result emitted; the first operation after release starts cleanly.

Structure
REQ-027 SHALL place the state enumeration and default width constant in shared package div_pkg.
REQ-028 SHALL use one sub-module div_step (combinational trial subtract, restore and quotient-bit select), instantiated once inside the sequential datapath.

Verification
REQ-029 SHALL cover normal division: dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0, out_valid 17 cycles after acceptance.
REQ-030 SHALL cover maximum in-range division: dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, flags 0.
REQ-031 SHALL cover divide-by-zero: dividend=32'h00001234, divisor=0 -> div_zero=1, quotient=16'hFFFF, remainder=16'h1234, out_valid 1 cycle after acceptance.
REQ-032 SHALL cover overflow: dividend=32'h00010000, divisor=1 -> overflow=1, quotient=16'hFFFF, remainder=0.
REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; in_valid pulsed during CALC -> ignored.
REQ-034 SHALL cover reset mid-CALC: rst_n low at step 8 -> all outputs reach reset values immediately; next operation 100/10 -> quotient=10, remainder=0.
